// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the 3-bit-opcode processor.
// A single memory port is shared between instruction fetch and load/store through a
// memReq/memAck handshake. Each handshake is bounded by a wait counter, and running out
// of time sends the sequencer into a terminal error state.
// Optional feature macro: MC_SEQ_ILLEGAL_TRAP_EN. When it is defined, illegal opcodes
// enter a terminal TRAP state. When it is undefined, illegal opcodes execute as NOPs and
// trap is held at 0.
module mc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       equal,
  input  logic       memAck,
  output logic       memReq,
  output logic       memWrite,
  output logic       iOrD,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcBranch,
  output logic       regWrite,
  output logic       memToReg,
  output logic       addition,
  output logic       aluF,
  output logic       halted,
  output logic       timeout,
  output logic       trap,
  output logic [3:0] state
);

  // The encoding is visible on the debug state port, so each value is fixed explicitly.
  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExec   = 4'd3,
    StMem    = 4'd4,
    StWb     = 4'd5,
    StHalt   = 4'd6,
    StErr    = 4'd7,
    StTrap   = 4'd8
  } state_e;

  localparam logic [2:0] OpStore = 3'b000;
  localparam logic [2:0] OpLoad  = 3'b001;
  localparam logic [2:0] OpAdd   = 3'b010;
  localparam logic [2:0] OpBeq   = 3'b101;
  localparam logic [2:0] OpHalt  = 3'b111;

  // Last wait cycle that is still allowed. An ack arriving in this cycle still wins.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;

  // State, wait counter and latched opcode. The reset is asynchronous, so an in-flight
  // request is dropped immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic and strobes. Outputs are Moore on state, except for the ack/equal
  // qualified strobes.
  always_comb begin
    state_d  = state_q;
    // The counter falls back to 0 whenever it is not counting, so it is already clear
    // on every entry to FETCH or MEM.
    cnt_d    = '0;
    op_d     = op_q;
    memReq   = 1'b0;
    memWrite = 1'b0;
    iOrD     = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcBranch = 1'b0;
    regWrite = 1'b0;
    memToReg = 1'b0;
    addition = 1'b0;
    aluF     = 1'b0;
    halted   = 1'b0;
    timeout  = 1'b0;
    trap     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end

      StFetch: begin
        memReq = 1'b1;
        if (memAck) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = StDecode;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDecode: begin
        op_d = op;
        case (op)
          OpStore, OpLoad: state_d = StMem;
          OpAdd, OpBeq:    state_d = StExec;
          OpHalt:          state_d = StHalt;
          default: begin
`ifdef MC_SEQ_ILLEGAL_TRAP_EN
            state_d = StTrap;
`else
            state_d = StFetch;
`endif
          end
        endcase
      end

      StExec: begin
        // Only add and beq can reach EXEC.
        if (op_q == OpAdd) begin
          addition = 1'b1;
          regWrite = 1'b1;
        end else begin
          aluF     = 1'b1;
          pcBranch = equal;
        end
        state_d = StFetch;
      end

      StMem: begin
        memReq   = 1'b1;
        iOrD     = 1'b1;
        // This comes from the latched opcode, so it holds steady for the whole request.
        memWrite = (op_q == OpStore);
        if (memAck) begin
          state_d = (op_q == OpStore) ? StFetch : StWb;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWb: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        state_d  = StFetch;
      end

      StHalt: begin
        halted = 1'b1;
      end

      StErr: begin
        timeout = 1'b1;
      end

`ifdef MC_SEQ_ILLEGAL_TRAP_EN
      StTrap: begin
        trap = 1'b1;
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the 3-bit-opcode processor.
- Replaces single-cycle control decode with a Moore/Mealy FSM.
- Shares one memory port between instruction fetch and load/store via a req/ack handshake.
- Drives the existing datapath strobes (regWrite, memWrite, memToReg, addition, aluF), plus PC/IR enables and halt/timeout status.

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory request may wait for memAck before error; legal range 2..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  leave IDLE and begin fetching
- op  in  3  opcode field from instruction register
- equal  in  1  datapath comparator result (operands equal)
- memAck  in  1  memory completes current request this cycle
- memReq  out  1  memory request valid
- memWrite  out  1  request is a write
- iOrD  out  1  address select: 0 = PC, 1 = data address
- irWrite  out  1  load instruction register
- pcWrite  out  1  PC <= PC+1
- pcBranch  out  1  PC <= branch target
- regWrite  out  1  register file write enable
- memToReg  out  1  write-back source: 1 = memory data
- addition  out  1  ALU add operation
- aluF  out  1  ALU compare operation
- halted  out  1  halt instruction executed
- timeout  out  1  memory handshake timed out
- trap  out  1  illegal opcode trapped; constant 0 when feature disabled
- state  out  4  current state encoding, debug only

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7, TRAP=8.
- Reset (async, any time, including mid-handshake):
  - state=IDLE, wait counter=0, latched opcode opQ=000.
  - All outputs 0.
  - Takes effect immediately; no pending request survives.
- IDLE: all outputs 0. start=1 -> FETCH next cycle.
- FETCH:
  - memReq=1, iOrD=0, memWrite=0.
  - If memAck=1 in the same cycle: irWrite=1 and pcWrite=1 (Mealy on ack) -> DECODE.
  - Ack in the first request cycle is legal.
- DECODE: opQ <= op; no strobes. Next state by op:
  - 000 store, 001 load -> MEM
  - 010 add, 101 beq -> EXEC
  - 111 halt -> HALT
  - 011, 100, 110 -> illegal handling (see Optional Feature)
- EXEC (uses opQ), then -> FETCH:
  - add: addition=1, regWrite=1.
  - beq: aluF=1; pcBranch=equal (Mealy on equal).
- MEM:
  - memReq=1, iOrD=1, memWrite=(opQ==000).
  - On memAck: store -> FETCH; load -> WB.
  - memWrite must be stable for the whole request.
- WB: regWrite=1, memToReg=1 -> FETCH.
- HALT: halted=1. Terminal until reset; start ignored.
- ERR: timeout=1. Terminal until reset.
- Wait counter:
  - Cleared on every entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM with memAck=0.
  - If memAck=0 and counter==MEM_TIMEOUT-1 -> ERR. memReq is dropped in ERR.
  - memAck on the last allowed cycle wins over timeout.
- memAck while memReq=0 is ignored.
- At most one of pcWrite/pcBranch asserted in any cycle.
- Minimum instruction latency (ack on first request cycle):
  - add and beq: 3 cycles.
  - store: 3 cycles.
  - load: 4 cycles.

Optional Feature:
- Macro: MC_SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal opcode in DECODE -> TRAP.
  - TRAP: trap=1, all other strobes 0; terminal until reset.
- Undefined:
  - Illegal opcode treated as NOP: DECODE -> FETCH, no strobes.
  - No TRAP state; trap tied 0.

Test Plan:
- Reset then start=1, memAck high always, op=010 -> state 1,2,3 repeating; irWrite/pcWrite pulse in FETCH; addition=1 and regWrite=1 in EXEC.
- op=001 with memAck delayed 3 cycles in MEM -> memReq=1 and iOrD=1 for 4 cycles, memWrite=0; then WB with regWrite=1, memToReg=1.
- op=101 with equal=1, then op=101 with equal=0 -> pcBranch=1 in the first EXEC and 0 in the second; aluF=1 in both.
- MEM_TIMEOUT=4, memAck never in FETCH -> ERR entered after 4 request cycles; timeout=1, memReq=0, persists until reset.
- op=111 -> halted=1 and stays; start pulses ignored; reset asserted -> halted=0 asynchronously, state=0.
- op=110 -> with macro: trap=1, terminal; without macro: next state FETCH, trap=0. Also: reset asserted mid-MEM of a store -> memWrite falls immediately.
